// File: rtl/addsub_pkg.sv
// Shared types and helpers for the sequential add/sub unit.
// States, operation codes and count-register sizing.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int cnt_width(input int nchunk);
        int w;
        w = $clog2(nchunk);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple slice; also exposes the carry into its MSB.
module addsub_chunk
#(
    parameter int CHUNK = 4
)
(
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/sub, CHUNK bits per cycle, valid/ready on both sides.
// Optional build macro ADDSUB_SAT_EN clamps signed overflow to min/max.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             xin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_d,
    output logic             co_bo,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             op_q, op_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [CHUNK-1:0] sl_a, sl_b, sl_sum;
    logic             sl_cout, sl_cmsb;
    logic [WIDTH-1:0] res_nx;
    logic             ovf_nx;
    int               base;

    assign base = int'(cnt_q) * CHUNK;
    assign sl_a = a_q[base +: CHUNK];
    assign sl_b = b_q[base +: CHUNK];

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout),
        .cmsb (sl_cmsb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        res_nx  = res_q;
        ovf_nx  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // b is stored pre-inverted so BUSY only ever adds
                    a_d     = a;
                    b_d     = (op == OP_SUB) ? ~b : b;
                    op_d    = op;
                    carry_d = (op == OP_SUB) ? ~xin : xin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                res_nx[base +: CHUNK] = sl_sum;
                carry_d = sl_cout;
                if (cnt_q == LAST) begin
                    ovf_nx = sl_cmsb ^ sl_cout;
                    co_d   = (op_q == OP_SUB) ? ~sl_cout : sl_cout;
                    ovf_d  = ovf_nx;
`ifdef ADDSUB_SAT_EN
                    if (ovf_nx) begin
                        res_nx = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                    zero_d  = (res_nx == '0);
                    neg_d   = res_nx[WIDTH-1];
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                res_d = res_nx;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= OP_ADD;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s_d       = res_q;
    assign co_bo     = co_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq at WIDTH=16, CHUNK=4.
// Expectations follow ADDSUB_SAT_EN when the bench is built with it.
module tb_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        xin = 1'b0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] s_d;
    logic        co_bo, ovf, zero, neg;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addsub_seq #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .xin       (xin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_d       (s_d),
        .co_bo     (co_bo),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                         input logic ix, input logic iop);
        a = ia;
        b = ib;
        xin = ix;
        op = iop;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
    endtask

    task automatic run_op(input string tag,
                          input logic [15:0] ia, input logic [15:0] ib,
                          input logic ix, input logic iop,
                          input logic [15:0] es, input logic eco,
                          input logic eovf, input logic ez, input logic en);
        issue(ia, ib, ix, iop);
        chk({tag, "_busy_rdy"}, {31'd0, in_ready}, 32'd0);
        repeat (3) step();
        chk({tag, "_early_vld"}, {31'd0, out_valid}, 32'd0);
        step();
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_s"}, {16'd0, s_d}, {16'd0, es});
        chk({tag, "_flags"}, {28'd0, co_bo, ovf, zero, neg},
            {28'd0, eco, eovf, ez, en});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_ret_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        #12;
        chk("rst_hs", {30'd0, out_valid, in_ready}, 32'd1);
        chk("rst_data", {12'd0, s_d, co_bo, ovf, zero, neg}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);

        run_op("add", 16'h1234, 16'h0FFF, 1'b0, 1'b0,
               16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub", 16'h0003, 16'h0005, 1'b0, 1'b1,
               16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op("chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0,
               16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef ADDSUB_SAT_EN
        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
               16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1,
               16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
`else
        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
               16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1,
               16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        run_op("sub_bin", 16'h0005, 16'h0005, 1'b1, 1'b1,
               16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);

        // backpressure: result must hold while new operands are offered
        issue(16'h0001, 16'h0002, 1'b0, 1'b0);
        repeat (4) step();
        chk("bp_vld", {31'd0, out_valid}, 32'd1);
        a = 16'h5555;
        b = 16'h1111;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", {12'd0, s_d, out_valid, in_ready, zero, neg},
                {12'd0, 16'h0003, 4'b1000});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
        step();
        chk("bp_no_accept", {30'd0, out_valid, in_ready}, 32'd1);

        // reset two cycles into BUSY discards the operation
        issue(16'h4444, 16'h1111, 1'b0, 1'b0);
        step();
        chk("mid_busy", {30'd0, out_valid, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst", {30'd0, out_valid, in_ready}, 32'd1);
        #4;
        rst_n = 1'b1;
        repeat (5) step();
        chk("rst_stay_idle", {30'd0, out_valid, in_ready}, 32'd1);

        run_op("after_rst", 16'h1111, 16'h2222, 1'b0, 1'b0,
               16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised, multi-cycle adder/subtractor with carry/borrow-in and status flags. Operands are WIDTH bits, processed CHUNK bits per cycle with the carry held in a register between chunks. A valid/ready handshake sits on both the input and the output side. The block is the sequential, width-generic successor to the team's 4-bit combinational add/sub unit, and it sits on datapaths where area matters more than single-cycle latency.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of CHUNK and at least 2.
- CHUNK, 4: bits processed per cycle; must be at least 1. NCHUNK = WIDTH/CHUNK.

Ports (reset: one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- xin  in  1  carry-in (add) / borrow-in (sub)
- op  in  1  0 = add, 1 = subtract
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- s_d  out  WIDTH  sum/difference
- co_bo  out  1  carry-out (add) / borrow-out (sub)
- ovf  out  1  two's-complement signed overflow
- zero  out  1  s_d == 0
- neg  out  1  s_d[WIDTH-1]

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: chunk counter runs 0..NCHUNK-1.
  - DONE: out_valid=1.
- Transitions:
  - IDLE→BUSY on in_valid && in_ready. At that edge a, b, xin and op are latched.
  - BUSY→DONE at the edge that processes chunk NCHUNK-1.
  - DONE→IDLE on out_valid && out_ready.
- Add: s_d = a + b + xin. co_bo = carry out of bit WIDTH-1.
- Subtract: s_d = a − b − xin, implemented as a + ~b + ~xin. co_bo = NOT(carry out of bit WIDTH-1), so co_bo=1 means a borrow occurred.
- Each BUSY cycle adds chunk k (bits k·CHUNK+CHUNK-1 .. k·CHUNK), least-significant chunk first. It uses the registered carry and writes the result bits into the s_d register.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, taken from the internal addition.
- zero and neg are computed from the final s_d, after saturation if that feature is compiled in.
- Inputs are ignored outside IDLE. Latched operands do not change if the a/b inputs change during BUSY.
- s_d, co_bo, ovf, zero and neg hold stable while in DONE. They are don't-care outside DONE, but in practice they hold their last value.

## Timing
- Reset values:
  - state = IDLE, so in_ready=1 once rst_n is high.
  - out_valid = 0.
  - s_d, co_bo, ovf, zero and neg = 0. neg is 0 because s_d is 0.
  - Internal carry and chunk counter = 0.
- Latency: accept at edge T; out_valid rises after edge T+NCHUNK.
- Best-case issue interval: NCHUNK+2 cycles. There is no accept in DONE and no overlap between operations.
- CHUNK = WIDTH gives a single BUSY cycle. The behaviour is unchanged.
- rst_n asserted in any state (including mid-BUSY) immediately returns the block to IDLE, drops out_valid and discards the operation in progress.
- in_valid held high in BUSY or DONE has no effect. The operation is accepted on the first IDLE edge.
- out_ready low in DONE holds the result indefinitely.

## Configuration
- ADDSUB_SAT_EN defined: on ovf=1, s_d is clamped.
  - Positive overflow clamps to 0 followed by all ones (max positive).
  - Negative overflow clamps to 1 followed by all zeros (min negative).
  - The direction comes from the sign of the latched a.
  - ovf still reads 1. co_bo is unaffected.
  - zero and neg reflect the clamped value.
  - The clamp is applied at the DONE transition, so there is no added latency.
- ADDSUB_SAT_EN undefined: results wrap modulo 2^WIDTH.

## Structure
- addsub_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - localparams OP_ADD=1'b0 and OP_SUB=1'b1;
  - a function computing the count-register width, $clog2 of NCHUNK with a minimum of 1.
- Sub-module addsub_chunk: combinational CHUNK-bit ripple slice. Inputs are a, b (already inverted for subtract) and cin. Outputs are sum, cout, and the carry into the slice MSB (needed for ovf). The top level instantiates one slice and multiplexes chunks through it by the counter.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Add: 0x1234 + 0x0FFF, xin=0 → s_d=0x2233, co_bo=0, ovf=0. out_valid rises 4 cycles after the accept edge.
- Subtract: 0x0003 − 0x0005, xin=0 → s_d=0xFFFE, co_bo=1, neg=1, ovf=0.
- Carry chain across all chunks: 0xFFFF + 0x0000, xin=1 → s_d=0x0000, co_bo=1, zero=1.
- Overflow, add: 0x7FFF + 0x0001 → s_d=0x8000, ovf=1, neg=1. With ADDSUB_SAT_EN → s_d=0x7FFF, ovf=1, neg=0.
- Overflow, subtract: 0x8000 − 0x0001 → s_d=0x7FFF, ovf=1. With ADDSUB_SAT_EN → s_d=0x8000.
- Handshake and reset:
  - Hold out_ready low for 5 cycles → result stable, in_ready=0, and a new in_valid is ignored.
  - Assert rst_n low after 2 BUSY cycles → out_valid=0 and the block returns to IDLE.
  - The next operation after reset then completes correctly.
